// File: rtl/linear2_weight_ctrl.sv
// Load/sweep sequencer for the layer-2 weight memory: streams weights in row-major
// order during load, then reads one full row per cycle and flags it to the MAC array.
module linear2_weight_ctrl #(
    parameter int unsigned DW     = 10,
    parameter int unsigned N_ROWS = 10,
    parameter int unsigned N_COLS = 10,
    parameter int unsigned AW     = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_start,
    input  logic          load_valid,
    input  logic [DW-1:0] load_data,
    output logic          load_ready,
    input  logic          start,
    output logic          busy,
    output logic          loaded,
    output logic          done,
    output logic          row_valid,
    output logic [AW-1:0] row_idx,
    output logic [DW-1:0] mem_datain,
    output logic [AW-1:0] mem_neural_addr,
    output logic [AW-1:0] mem_weight_addr,
    output logic          mem_wt,
    output logic          mem_rd
);

    localparam logic [AW-1:0] ROW_LAST = AW'(N_ROWS - 1);
    localparam logic [AW-1:0] COL_LAST = AW'(N_COLS - 1);

    typedef enum logic [2:0] {IDLE, LOAD, READY, SWEEP, WRAP} state_t;

    state_t        state, state_nx;
    logic [AW-1:0] row_cnt, col_cnt, row_cnt_nx, col_cnt_nx;
    logic          load_ready_nx, busy_nx, loaded_nx, done_nx, row_valid_nx;
    logic [AW-1:0] row_idx_nx, neural_addr_nx, weight_addr_nx;
    logic [DW-1:0] datain_nx;
    logic          wt_nx, rd_nx;
    logic          hs, last_word, last_row;

    assign hs        = (state == LOAD) && load_valid && load_ready;
    assign last_word = hs && (row_cnt == ROW_LAST) && (col_cnt == COL_LAST);
    assign last_row  = (row_cnt == ROW_LAST);

    // State, counter and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            row_cnt         <= '0;
            col_cnt         <= '0;
            load_ready      <= 1'b0;
            busy            <= 1'b0;
            loaded          <= 1'b0;
            done            <= 1'b0;
            row_valid       <= 1'b0;
            row_idx         <= '0;
            mem_datain      <= '0;
            mem_neural_addr <= '0;
            mem_weight_addr <= '0;
            mem_wt          <= 1'b0;
            mem_rd          <= 1'b0;
        end else begin
            state           <= state_nx;
            row_cnt         <= row_cnt_nx;
            col_cnt         <= col_cnt_nx;
            load_ready      <= load_ready_nx;
            busy            <= busy_nx;
            loaded          <= loaded_nx;
            done            <= done_nx;
            row_valid       <= row_valid_nx;
            row_idx         <= row_idx_nx;
            mem_datain      <= datain_nx;
            mem_neural_addr <= neural_addr_nx;
            mem_weight_addr <= weight_addr_nx;
            mem_wt          <= wt_nx;
            mem_rd          <= rd_nx;
        end
    end

    // Next state; load_start has priority over start
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (load_start) state_nx = LOAD;
            READY: begin
                if (load_start)      state_nx = LOAD;
                else if (start)      state_nx = SWEEP;
            end
            LOAD:    if (last_word)  state_nx = READY;
            SWEEP:   if (last_row)   state_nx = WRAP;
            WRAP:                    state_nx = READY;
            default:                 state_nx = IDLE;
        endcase
    end

    // Next register values; the extra rd in WRAP rewraps the memory's row pointer
    always_comb begin
        row_cnt_nx     = row_cnt;
        col_cnt_nx     = col_cnt;
        wt_nx          = 1'b0;
        rd_nx          = 1'b0;
        done_nx        = 1'b0;
        row_valid_nx   = 1'b0;
        row_idx_nx     = row_idx;
        datain_nx      = mem_datain;
        neural_addr_nx = mem_neural_addr;
        weight_addr_nx = mem_weight_addr;
        load_ready_nx  = (state_nx == LOAD);
        busy_nx        = (state_nx == LOAD) || (state_nx == SWEEP) || (state_nx == WRAP);
        loaded_nx      = (state_nx == READY) || (state_nx == SWEEP) || (state_nx == WRAP);
        case (state)
            IDLE, READY: begin
                if (state_nx != state) begin
                    row_cnt_nx = '0;
                    col_cnt_nx = '0;
                end
                rd_nx = (state_nx == SWEEP);
            end
            LOAD: begin
                if (hs) begin
                    wt_nx          = 1'b1;
                    datain_nx      = load_data;
                    neural_addr_nx = row_cnt;
                    weight_addr_nx = col_cnt;
                    if (col_cnt == COL_LAST) begin
                        col_cnt_nx = '0;
                        row_cnt_nx = row_cnt + AW'(1);
                    end else begin
                        col_cnt_nx = col_cnt + AW'(1);
                    end
                end
            end
            SWEEP: begin
                rd_nx        = 1'b1;
                row_valid_nx = 1'b1;
                row_idx_nx   = row_cnt;
                row_cnt_nx   = row_cnt + AW'(1);
            end
            WRAP:    done_nx = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: doc/linear2_weight_ctrl.md
Name: linear2_weight_ctrl

Overview:
- Sequencer for the 10x10 layer-2 weight memory.
- Load phase: accepts a row-major stream of weight words over a valid/ready handshake and generates the memory write strobes and addresses.
- Sweep phase: drives the read strobe so the memory emits one full row (N_COLS weights in parallel) per cycle. Flags each row to the downstream MAC array with row_valid/row_idx, then pulses done.

Parameters:
DW, 10, weight word width
N_ROWS, 10, neurons (rows) per sweep
N_COLS, 10, weights per neuron
AW, 4, address width of neural_addr/weight_addr

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
load_start  input  1  pulse: begin weight load (IDLE or READY only)
load_valid  input  1  load word valid
load_data  input  DW  load word, row-major, column index fastest
load_ready  output  1  controller accepts load word
start  input  1  pulse: begin one read sweep (READY only)
busy  output  1  LOAD, SWEEP or WRAP active
loaded  output  1  full weight set resident in memory
done  output  1  one-cycle pulse at end of sweep
row_valid  output  1  memory dataout0..N_COLS-1 hold row row_idx this cycle
row_idx  output  AW  row index qualifying row_valid
mem_datain  output  DW  to memory datain
mem_neural_addr  output  AW  to memory neural_addr
mem_weight_addr  output  AW  to memory weight_addr
mem_wt  output  1  to memory wt
mem_rd  output  1  to memory rd

Behaviour:
- All outputs are registered.
- Reset (async, any state, including mid-load or mid-sweep):
  - state = IDLE.
  - All outputs = 0, including loaded.
  - Weights are considered invalid after any reset.
- States: IDLE, LOAD, READY, SWEEP, WRAP.
- IDLE / READY:
  - load_start → LOAD.
  - start in READY → SWEEP.
  - start in IDLE is ignored.
  - If load_start and start are sampled high on the same edge, load_start wins.
- LOAD:
  - load_ready = 1 and loaded = 0.
  - On each handshake (load_valid & load_ready at an edge), the next cycle drives mem_wt=1, mem_datain=load_data, mem_neural_addr=row cnt, mem_weight_addr=col cnt.
  - col cnt increments on each handshake and wraps at N_COLS-1 → 0 with row cnt+1.
  - mem_wt = 0 on cycles following no handshake; gaps are allowed.
  - After handshake number N_ROWS*N_COLS: load_ready drops next cycle, final write issued that cycle, state → READY, loaded = 1.
  - start and load_start are ignored in LOAD.
- Memory read-pointer contract:
  - Any write zeroes the memory's internal row pointer.
  - Each rd cycle outputs row[ptr] and increments ptr while ptr < N_ROWS; at ptr == N_ROWS the rd cycle only rewraps ptr to 0 and produces no output.
  - The controller therefore issues exactly N_ROWS+1 rd cycles per sweep.
  - Starting a sweep only with loaded = 1 guarantees ptr = 0 at sweep start.
- SWEEP / WRAP, with start sampled at edge E0:
  - mem_rd = 1 for cycles after E0 .. E(N_ROWS). The last of these is WRAP.
  - Row r output is valid after edge E(r+1); row_valid = 1 and row_idx = r during that cycle, for r = 0..N_ROWS-1.
  - After edge E(N_ROWS+1): row_valid = 0, done = 1 for one cycle, busy = 0, state = READY.
  - Sweeps can repeat back-to-back: start in the done cycle launches the next sweep.
- Invariants:
  - mem_wt & mem_rd is never 1.
  - row_idx holds its last value while row_valid = 0.
  - Counters are AW wide; N_ROWS and N_COLS ≤ 2^AW.

Test Plan:
- Reset → all outputs 0; start pulsed while loaded = 0 → no mem_rd and busy stays 0 for 20 cycles.
- load_start, then 100 words with data = 10*row+col, load_valid continuous → 100 mem_wt cycles with matching addresses; loaded = 1 one cycle after the last write; memory content [7][3] = 73.
- Load with load_valid toggled 1,0,1,0 → mem_wt only follows handshakes; word count and addresses still total 100, last write to (9,9).
- start after load → mem_rd high for 11 cycles; row_valid high 10 cycles with row_idx 0..9; dataout3 = 10*row_idx+3 on each; done pulses once; second start in the done cycle repeats an identical sequence.
- rst_n asserted at row_idx = 5 mid-sweep → outputs 0 immediately, loaded = 0; start ignored until reload, after which a sweep again begins at row 0.
- load_start and start high on the same edge in READY → LOAD entered, no mem_rd issued.
